// File: rtl/sync_fifo.sv
// Single-clock FIFO: register-array storage with wrapping read/write pointers,
// an occupancy counter, registered read data and count-decoded empty/full flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wt_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  mem_empty,
  output logic                  mem_full
);

  localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
  logic                  wrAccept;
  logic                  rdAccept;

  assign mem_empty = (count_q == '0);
  assign mem_full  = (count_q == FullCount);
  assign data_out  = dataOut_q;

  // A read frees a slot this cycle, so a full FIFO can still take a write
  // alongside it; an empty FIFO never bypasses write data to the output.
  always_comb begin
    rdAccept = rd_en && !mem_empty;
    wrAccept = wt_en && (!mem_full || rdAccept);
  end

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    dataOut_d = dataOut_q;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (rdAccept) begin
      rdPtr_d   = rdPtr_q + 1'b1;
      dataOut_d = mem_q[rdPtr_q];
    end
    case ({wrAccept, rdAccept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      dataOut_q <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      dataOut_q <= dataOut_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && wrAccept) begin
      mem_q[wrPtr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a queue scoreboard models accepted writes and
// reads, and every step compares data_out and both flags against it.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic [3:0] data_in;
  logic       wt_en;
  logic       rd_en;
  logic [3:0] data_out;
  logic       mem_empty;
  logic       mem_full;

  int testsRun;
  int testsFailed;

  logic [3:0] sbQueue [$];
  logic [3:0] modelDout;
  logic [3:0] fillData [16];

  sync_fifo #(.DATA_WIDTH(4), .DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .wt_en    (wt_en),
    .rd_en    (rd_en),
    .data_out (data_out),
    .mem_empty(mem_empty),
    .mem_full (mem_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".data_out"}, {4'h0, data_out}, {4'h0, modelDout});
    checkOutput({tag, ".empty"}, {7'h0, mem_empty}, {7'h0, (sbQueue.size() == 0)});
    checkOutput({tag, ".full"}, {7'h0, mem_full}, {7'h0, (sbQueue.size() == 16)});
  endtask

  // One clock of stimulus; the scoreboard decides acceptance from its own
  // pre-edge occupancy, then is updated (pop before push) after the edge.
  task automatic applyStimulus(input string tag, input logic wt, input logic rd, input logic [3:0] din);
    logic rdOk;
    logic wrOk;
    wt_en   = wt;
    rd_en   = rd;
    data_in = din;
    rdOk = rd && (sbQueue.size() > 0);
    wrOk = wt && ((sbQueue.size() < 16) || rdOk);
    @(posedge clk);
    #1;
    if (rdOk) modelDout = sbQueue.pop_front();
    if (wrOk) sbQueue.push_back(din);
    wt_en = 1'b0;
    rd_en = 1'b0;
    checkAll(tag);
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wt_en = 1'b0;
    rd_en = 1'b0;
    sbQueue.delete();
    modelDout = 4'h0;
    checkAll(tag);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b0;
    wt_en       = 1'b0;
    rd_en       = 1'b0;
    data_in     = 4'h0;
    modelDout   = 4'h0;
    fillData = '{4'h0, 4'h3, 4'h6, 4'h8, 4'h2, 4'h4, 4'hA, 4'h7,
                 4'hB, 4'h6, 4'h8, 4'h2, 4'h4, 4'hA, 4'h7, 4'hB};

    @(posedge clk);
    #1;
    applyReset("reset");
    checkOutput("reset.dout_const", {4'h0, data_out}, 8'h00);
    applyStimulus("rd_empty", 1'b0, 1'b1, 4'h0);
    applyStimulus("rd_empty2", 1'b0, 1'b1, 4'h0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus("fill", 1'b1, 1'b0, fillData[i]);
      if (i == 0) checkOutput("fill.first_not_empty", {7'h0, mem_empty}, 8'h00);
    end
    checkOutput("fill.full_const", {7'h0, mem_full}, 8'h01);
    applyStimulus("overflow", 1'b1, 1'b0, 4'hF);
    checkOutput("overflow.full_const", {7'h0, mem_full}, 8'h01);

    for (int i = 0; i < 16; i++) begin
      applyStimulus("drain", 1'b0, 1'b1, 4'h0);
      checkOutput("drain.order", {4'h0, data_out}, {4'h0, fillData[i]});
    end
    applyStimulus("drain.extra", 1'b0, 1'b1, 4'h0);
    checkOutput("drain.hold_b", {4'h0, data_out}, 8'h0B);

    for (int i = 0; i < 10; i++) applyStimulus("wrap.w10", 1'b1, 1'b0, 4'(i + 3));
    for (int i = 0; i < 10; i++) applyStimulus("wrap.r10", 1'b0, 1'b1, 4'h0);
    for (int i = 1; i <= 9; i++) applyStimulus("wrap.w9", 1'b1, 1'b0, 4'(i));
    for (int i = 1; i <= 9; i++) begin
      applyStimulus("wrap.r9", 1'b0, 1'b1, 4'h0);
      checkOutput("wrap.value", {4'h0, data_out}, 8'(i));
    end

    for (int i = 0; i < 16; i++) applyStimulus("full.fill", 1'b1, 1'b0, 4'(15 - i));
    applyStimulus("full.both", 1'b1, 1'b1, 4'h5);
    checkOutput("full.both_oldest", {4'h0, data_out}, 8'h0F);
    checkOutput("full.both_full", {7'h0, mem_full}, 8'h01);
    for (int i = 0; i < 16; i++) applyStimulus("full.drain", 1'b0, 1'b1, 4'h0);
    checkOutput("full.last_is_5", {4'h0, data_out}, 8'h05);

    applyStimulus("empty.both", 1'b1, 1'b1, 4'hC);
    checkOutput("empty.both_hold", {4'h0, data_out}, 8'h05);
    applyStimulus("empty.read_c", 1'b0, 1'b1, 4'h0);
    checkOutput("empty.got_c", {4'h0, data_out}, 8'h0C);

    for (int i = 0; i < 8; i++) applyStimulus("mid.fill", 1'b1, 1'b0, 4'(i + 1));
    applyStimulus("mid.read", 1'b0, 1'b1, 4'h0);
    applyStimulus("mid.read", 1'b0, 1'b1, 4'h0);
    rd_en = 1'b1;
    wt_en = 1'b1;
    data_in = 4'hE;
    applyReset("mid.reset");
    applyStimulus("post.write", 1'b1, 1'b0, 4'h9);
    applyStimulus("post.read", 1'b0, 1'b1, 4'h0);
    checkOutput("post.got_9", {4'h0, data_out}, 8'h09);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
